// File: rtl/output_channel_ctrl.sv
// Output port controller: one single-flit buffer per VC, written in the internal phase and drained onto the link in the other.
// Optional build macro OUTPUT_CTRL_VC_CHECK_EN drops accepted writes whose VC bit disagrees with the target buffer.
module output_channel_ctrl #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              even_out_enable,
  input  logic [DATA_W-1:0] even_out_data,
  input  logic              odd_out_enable,
  input  logic [DATA_W-1:0] odd_out_data,
  input  logic              ri,
  output logic              polarity,
  output logic              even_out_empty,
  output logic              odd_out_empty,
  output logic              so,
  output logic [DATA_W-1:0] do_data,
  output logic [15:0]       sent_count,
  output logic              vc_err
);

  typedef enum logic {PH_EVEN = 1'b0, PH_ODD = 1'b1} phase_t;

  phase_t            phase_reg, phase_next;
  logic [1:0]        internal_sel;
  logic [1:0]        wr_req;
  logic [DATA_W-1:0] wr_data [2];
  logic [1:0]        full_flag;
  logic [DATA_W-1:0] buf_word [2];
  logic [1:0]        wr_accept;
  logic [1:0]        rd_hit;
`ifdef OUTPUT_CTRL_VC_CHECK_EN
  logic [1:0]        wr_bad;
`endif

  logic              so_reg, so_next;
  logic [DATA_W-1:0] do_reg, do_next;
  logic [15:0]       cnt_reg, cnt_next;

  assign wr_req     = {odd_out_enable, even_out_enable};
  assign wr_data[0] = even_out_data;
  assign wr_data[1] = odd_out_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase_reg <= PH_EVEN;
    else        phase_reg <= phase_next;
  end

  // Phase flips every edge; internal_sel marks the VC that may be written this cycle.
  always_comb begin
    phase_next   = phase_reg;
    internal_sel = 2'b00;
    case (phase_reg)
      PH_EVEN: begin
        phase_next   = PH_ODD;
        internal_sel = 2'b01;
      end
      PH_ODD: begin
        phase_next   = PH_EVEN;
        internal_sel = 2'b10;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vc
      logic              full_reg, full_next;
      logic [DATA_W-1:0] buf_reg, buf_next;
      logic              wr_hit;
      logic              vc_ok;

      assign wr_hit = wr_req[gi] && internal_sel[gi] && !full_reg;
`ifdef OUTPUT_CTRL_VC_CHECK_EN
      assign vc_ok      = (wr_data[gi][DATA_W-1] == 1'(gi));
      assign wr_bad[gi] = wr_hit && !vc_ok;
`else
      assign vc_ok = 1'b1;
`endif
      assign wr_accept[gi] = wr_hit && vc_ok;
      // A buffer is only drained while it is the link VC, so write and drain never coincide.
      assign rd_hit[gi]    = full_reg && !internal_sel[gi] && ri;

      always_comb begin
        full_next = full_reg;
        buf_next  = buf_reg;
        if (wr_accept[gi]) begin
          full_next = 1'b1;
          buf_next  = wr_data[gi];
        end else if (rd_hit[gi]) begin
          full_next = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          full_reg <= 1'b0;
          buf_reg  <= '0;
        end else begin
          full_reg <= full_next;
          buf_reg  <= buf_next;
        end
      end

      assign full_flag[gi] = full_reg;
      assign buf_word[gi]  = buf_reg;
    end
  endgenerate

  always_comb begin
    so_next  = 1'b0;
    do_next  = do_reg;
    cnt_next = cnt_reg;
    if (|rd_hit) begin
      so_next  = 1'b1;
      do_next  = rd_hit[1] ? buf_word[1] : buf_word[0];
      cnt_next = cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      so_reg  <= 1'b0;
      do_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      so_reg  <= so_next;
      do_reg  <= do_next;
      cnt_reg <= cnt_next;
    end
  end

`ifdef OUTPUT_CTRL_VC_CHECK_EN
  logic err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err_reg <= 1'b0;
    else if (|wr_bad) err_reg <= 1'b1;
  end

  assign vc_err = err_reg;
`else
  assign vc_err = 1'b0;
`endif

  assign polarity       = (phase_reg == PH_ODD);
  assign even_out_empty = ~full_flag[0];
  assign odd_out_empty  = ~full_flag[1];
  assign so             = so_reg;
  assign do_data        = do_reg;
  assign sent_count     = cnt_reg;

endmodule

// File: tb/tb_output_channel_ctrl.sv
// Bench for output_channel_ctrl: directed scenarios plus randomized traffic against a slot-level reference model.
module tb_output_channel_ctrl;

  localparam int DATA_W = 64;
`ifdef OUTPUT_CTRL_VC_CHECK_EN
  localparam logic VC_CHECK = 1'b1;
`else
  localparam logic VC_CHECK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              even_out_enable = 1'b0;
  logic [DATA_W-1:0] even_out_data = '0;
  logic              odd_out_enable = 1'b0;
  logic [DATA_W-1:0] odd_out_data = '0;
  logic              ri = 1'b0;
  logic              polarity, even_out_empty, odd_out_empty, so, vc_err;
  logic [DATA_W-1:0] do_data;
  logic [15:0]       sent_count;

  always #5 clk = ~clk;

  output_channel_ctrl #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .even_out_enable(even_out_enable), .even_out_data(even_out_data),
    .odd_out_enable(odd_out_enable), .odd_out_data(odd_out_data),
    .ri(ri), .polarity(polarity),
    .even_out_empty(even_out_empty), .odd_out_empty(odd_out_empty),
    .so(so), .do_data(do_data), .sent_count(sent_count), .vc_err(vc_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one slot per VC, phase = parity of edges since reset release.
  logic        m_pol;
  logic        m_full [2];
  logic [63:0] m_buf [2];
  logic        m_so;
  logic [63:0] m_do;
  logic [15:0] m_cnt;
  logic        m_err;

  localparam logic [84:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 16'h0, 1'b0};

  logic [84:0] dut_vec;
  assign dut_vec = {polarity, even_out_empty, odd_out_empty, so, do_data, sent_count, vc_err};

  function automatic logic [84:0] exp_vec();
    return {m_pol, !m_full[0], !m_full[1], m_so, m_do, m_cnt, m_err};
  endfunction

  task automatic model_reset();
    m_pol = 1'b0;
    m_full[0] = 1'b0; m_full[1] = 1'b0;
    m_buf[0] = '0;    m_buf[1] = '0;
    m_so = 1'b0; m_do = '0; m_cnt = '0; m_err = 1'b0;
  endtask

  // Drive one cycle of inputs, let the edge pass, advance the model; returns 1ns after the edge.
  task automatic cycle(input logic we, input logic [63:0] de, input logic wo,
                       input logic [63:0] dodd, input logic r);
    int iv, lv;
    logic        wen;
    logic [63:0] wd;
    even_out_enable = we; even_out_data = de;
    odd_out_enable  = wo; odd_out_data  = dodd;
    ri = r;
    @(posedge clk);
    iv = m_pol ? 1 : 0;
    lv = 1 - iv;
    if (m_full[lv] && r) begin
      m_so = 1'b1; m_do = m_buf[lv]; m_full[lv] = 1'b0; m_cnt = m_cnt + 16'd1;
    end else begin
      m_so = 1'b0;
    end
    wen = (iv == 0) ? we : wo;
    wd  = (iv == 0) ? de : dodd;
    if (wen && !m_full[iv]) begin
      if (VC_CHECK && (wd[63] != m_pol)) m_err = 1'b1;
      else begin m_full[iv] = 1'b1; m_buf[iv] = wd; end
    end
    m_pol = ~m_pol;
    #1;
  endtask

  task automatic apply_reset();
    even_out_enable = 1'b0; odd_out_enable = 1'b0; ri = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++; $display("FAIL reset_async: got %h exp %h", dut_vec, RESET_VEC);
    end
    apply_reset();
    for (int i = 1; i <= 6; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== {logic'(i % 2), RESET_VEC[83:0]}) begin
        errors++; $display("FAIL reset_idle cyc %0d: got %h exp pol=%0d rest reset", i, dut_vec, i % 2);
      end
    end
  endtask

  task automatic test_single_flit();
    apply_reset();
    cycle(1, 64'hA5, 0, 0, 1);
    checks++;
    if (even_out_empty !== 1'b0 || so !== 1'b0) begin
      errors++; $display("FAIL single_write: empty=%b so=%b exp 0 0", even_out_empty, so);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (so !== 1'b1 || do_data !== 64'hA5 || sent_count !== 16'd1 || even_out_empty !== 1'b1) begin
      errors++; $display("FAIL single_emit: so=%b do=%h cnt=%0d empty=%b exp 1 a5 1 1",
                         so, do_data, sent_count, even_out_empty);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (dut_vec !== exp_vec() || so !== 1'b0) begin
      errors++; $display("FAIL single_after: got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_ri_stall();
    int pulses = 0;
    apply_reset();
    cycle(1, 64'hA5, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (so !== 1'b0 || even_out_empty !== 1'b0) begin
      errors++; $display("FAIL stall_hold: so=%b empty=%b exp 0 0", so, even_out_empty);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 1);
      if (so === 1'b1) pulses++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL stall_cyc %0d: got %h exp %h", i, dut_vec, exp_vec());
      end
      if (i == 1) begin
        checks++;
        if (so !== 1'b1 || do_data !== 64'hA5) begin
          errors++; $display("FAIL stall_retry: so=%b do=%h exp 1 a5", so, do_data);
        end
      end
    end
    checks++;
    if (pulses != 1 || sent_count !== 16'd1) begin
      errors++; $display("FAIL stall_pulses: pulses=%0d cnt=%0d exp 1 1", pulses, sent_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] fe, fo;
    fe = 64'h0123_4567_89AB_CDEF & ~(64'h1 << 63);
    fo = 64'h8765_4321_0FED_CBA9 | (64'h1 << 63);
    apply_reset();
    cycle(1, fe, 0, 0, 1);
    cycle(0, 0, 1, fo, 1);
    checks++;
    if (so !== 1'b1 || do_data !== fe) begin
      errors++; $display("FAIL b2b_first: so=%b do=%h exp 1 %h", so, do_data, fe);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (so !== 1'b1 || do_data !== fo || sent_count !== 16'd2) begin
      errors++; $display("FAIL b2b_second: so=%b do=%h cnt=%0d exp 1 %h 2", so, do_data, sent_count, fo);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (so !== 1'b0) begin
      errors++; $display("FAIL b2b_end: so=%b exp 0", so);
    end
  endtask

  task automatic test_ignored();
    int pulses = 0;
    apply_reset();
    cycle(1, 64'h11, 1, 64'h8000_0000_0000_0022, 0);
    checks++;
    if (odd_out_empty !== 1'b1 || even_out_empty !== 1'b0) begin
      errors++; $display("FAIL ign_wrong_vc: odd_empty=%b even_empty=%b exp 1 0", odd_out_empty, even_out_empty);
    end
    cycle(0, 0, 0, 0, 0);
    cycle(1, 64'h33, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 1);
      if (so === 1'b1) pulses++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ign_cyc %0d: got %h exp %h", i, dut_vec, exp_vec());
      end
      if (i == 0) begin
        checks++;
        if (so !== 1'b1 || do_data !== 64'h11) begin
          errors++; $display("FAIL ign_content: so=%b do=%h exp 1 11", so, do_data);
        end
      end
    end
    checks++;
    if (pulses != 1 || sent_count !== 16'd1) begin
      errors++; $display("FAIL ign_pulses: pulses=%0d cnt=%0d exp 1 1", pulses, sent_count);
    end
  endtask

  task automatic test_vc_check();
    apply_reset();
    cycle(1, 64'h8000_0000_0000_00A5, 0, 0, 1);
    checks++;
    if (even_out_empty !== VC_CHECK || vc_err !== VC_CHECK) begin
      errors++; $display("FAIL vc_check_write: empty=%b err=%b exp %b %b", even_out_empty, vc_err, VC_CHECK, VC_CHECK);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (so !== !VC_CHECK || vc_err !== VC_CHECK) begin
      errors++; $display("FAIL vc_check_emit: so=%b err=%b exp %b %b", so, vc_err, !VC_CHECK, VC_CHECK);
    end
    repeat (3) cycle(0, 0, 0, 0, 0);
    checks++;
    if (vc_err !== VC_CHECK) begin
      errors++; $display("FAIL vc_check_sticky: err=%b exp %b", vc_err, VC_CHECK);
    end
  endtask

  task automatic test_random();
    logic [63:0] de, dodd;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      de   = {$urandom, $urandom};
      dodd = {$urandom, $urandom};
      de[63]   = ($urandom_range(0, 9) == 0);
      dodd[63] = ($urandom_range(0, 9) != 0);
      cycle(logic'($urandom_range(0, 1)), de, logic'($urandom_range(0, 1)), dodd,
            logic'($urandom_range(0, 3) != 0));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] d;
    apply_reset();
    for (int i = 0; i < 65536; i++) begin
      d = {32'(i), 32'(~i)};
      if (m_pol) cycle(0, 0, 1, d | (64'h1 << 63), 1);
      else       cycle(1, d & ~(64'h1 << 63), 0, 0, 1);
      if (i == 1000) begin
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL wrap_mid: got %h exp %h", dut_vec, exp_vec());
        end
      end
    end
    checks++;
    if (sent_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_pre: cnt=%h exp ffff", sent_count);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (sent_count !== 16'h0000 || so !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL wrap_zero: cnt=%h so=%b exp 0000 1", sent_count, so);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    cycle(1, 64'h5A5A, 0, 0, 0);
    cycle(0, 0, 1, 64'h8000_0000_0000_0077, 0);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++; $display("FAIL async_now: got %h exp %h", dut_vec, RESET_VEC);
    end
    even_out_enable = 1'b0; odd_out_enable = 1'b0; ri = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++; $display("FAIL async_hold: got %h exp %h", dut_vec, RESET_VEC);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 1);
      checks++;
      if (so !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL async_after cyc %0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_flit();
    test_ri_stall();
    test_back_to_back();
    test_ignored();
    test_vc_check();
    test_random();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
